// File: rtl/arm7_pkg.sv
// Shared types and constants for the ARM7 sequencer and its helpers.
package arm7_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_DWAIT,
        ST_EXEC,
        ST_COMMIT,
        ST_FAULT
    } seq_state_e;

    typedef enum logic [1:0] {
        CLS_BR,
        CLS_ALU,
        CLS_SDT,
        CLS_SKIP
    } instr_class_e;

    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] PC_PIPE_OFFSET = 32'd8;

    // ARM condition field encodings (instr[31:28]), shared with the decoder.
    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } arm_cond_e;

endpackage

// File: rtl/arm7_branch_target.sv
// Branch target: pc + 8 + (sign-extended word offset << 2), wrapping at 32 bits.
module arm7_branch_target
    import arm7_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [23:0] branch_offset,
    output logic [31:0] target
);

    logic [31:0] off_bytes;

    assign off_bytes = {{6{branch_offset[23]}}, branch_offset, 2'b00};
    assign target    = pc + PC_PIPE_OFFSET + off_bytes;

endmodule

// File: rtl/arm7_sequencer.sv
// Single-issue instruction sequencer: fetch, decode handshake, dispatch wait, commit.
module arm7_sequencer
    import arm7_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DECODE_LAT   = 3,
    parameter int unsigned EXEC_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        decode_en,
    input  logic        branch_en,
    input  logic        branch_cond,
    input  logic        branch_link,
    input  logic [23:0] branch_offset,
    input  logic        alu_en,
    input  logic        sdt_en,
    input  logic        alu_done,
    input  logic        sdt_done,
    output logic        lr_we,
    output logic [31:0] lr_wdata,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        fault
);

    localparam logic [7:0] DLAT_LAST = 8'(DECODE_LAT - 1);
    localparam logic [7:0] ETO_LAST  = 8'(EXEC_TIMEOUT - 1);

    seq_state_e   state_q, state_d;
    instr_class_e cls_q, cls_d;
    logic [31:0]  pc_q, pc_d, instr_q, instr_d, retired_q, retired_d;
    logic [31:0]  lr_wdata_q, lr_wdata_d;
    logic         seen_q, seen_d, cond_q, cond_d, link_q, link_d;
    logic [23:0]  off_q, off_d;
    logic [7:0]   cnt_q, cnt_d;

    logic [31:0]  br_target;
    logic [2:0]   strb;
    logic         strb_any, strb_multi, take;

    arm7_branch_target u_target (
        .pc            (pc_q),
        .branch_offset (off_q),
        .target        (br_target)
    );

    assign strb       = {sdt_en, alu_en, branch_en};
    assign strb_any   = |strb;
    assign strb_multi = |(strb & (strb - 3'd1));
    assign take       = (cls_q == CLS_BR) && cond_q;

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        lr_wdata_d = lr_wdata_q;
        seen_d     = seen_q;
        cond_d     = cond_q;
        link_d     = link_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        imem_req   = 1'b0;
        decode_en  = 1'b0;
        lr_we      = 1'b0;
        lr_wdata   = lr_wdata_q;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                decode_en = 1'b1;
                cnt_d     = 8'd0;
                seen_d    = 1'b0;
                cls_d     = CLS_SKIP;
                state_d   = ST_DWAIT;
            end
            ST_DWAIT: begin
                cnt_d = cnt_q + 8'd1;
                // Any second strobe, simultaneous or later, means the decoder misbehaved.
                if (strb_multi || (strb_any && seen_q)) begin
                    state_d = ST_FAULT;
                end else begin
                    if (strb_any) begin
                        seen_d = 1'b1;
                        if (branch_en) begin
                            cls_d  = CLS_BR;
                            cond_d = branch_cond;
                            link_d = branch_link;
                            off_d  = branch_offset;
                        end else if (alu_en) begin
                            cls_d = CLS_ALU;
                        end else begin
                            cls_d = CLS_SDT;
                        end
                    end
                    if (cnt_q == DLAT_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = (cls_d == CLS_ALU || cls_d == CLS_SDT) ? ST_EXEC : ST_COMMIT;
                    end
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 8'd1;
                if ((cls_q == CLS_ALU && alu_done) || (cls_q == CLS_SDT && sdt_done))
                    state_d = ST_COMMIT;
                else if (cnt_q == ETO_LAST)
                    state_d = ST_FAULT;
            end
            ST_COMMIT: begin
                pc_d      = take ? br_target : pc_q + PC_STEP;
                retired_d = retired_q + 32'd1;
                // Link value is presented alongside the strobe and also retained afterwards.
                if (take && link_q) begin
                    lr_we      = 1'b1;
                    lr_wdata   = pc_q + PC_STEP;
                    lr_wdata_d = pc_q + PC_STEP;
                end
                state_d = ST_FETCH;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            cls_q      <= CLS_SKIP;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            retired_q  <= 32'd0;
            lr_wdata_q <= 32'd0;
            seen_q     <= 1'b0;
            cond_q     <= 1'b0;
            link_q     <= 1'b0;
            off_q      <= 24'd0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            lr_wdata_q <= lr_wdata_d;
            seen_q     <= seen_d;
            cond_q     <= cond_d;
            link_q     <= link_d;
            off_q      <= off_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_arm7_sequencer.sv
// Directed bench for arm7_sequencer: one instruction at a time, expectations worked out by hand.
module tb_arm7_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready, decode_en, lr_we, fault;
    logic [31:0] imem_addr, imem_rdata, instr, lr_wdata, pc, retired;
    logic        branch_en, branch_cond, branch_link, alu_en, sdt_en, alu_done, sdt_done;
    logic [23:0] branch_offset;

    int total = 0;
    int bad   = 0;
    int ncyc, lw_cnt, de_cnt, cyc;
    logic [31:0] lw_data;

    arm7_sequencer #(
        .RESET_PC     (32'h0000_0100),
        .DECODE_LAT   (3),
        .EXEC_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .decode_en     (decode_en),
        .branch_en     (branch_en),
        .branch_cond   (branch_cond),
        .branch_link   (branch_link),
        .branch_offset (branch_offset),
        .alu_en        (alu_en),
        .sdt_en        (sdt_en),
        .alu_done      (alu_done),
        .sdt_done      (sdt_done),
        .lr_we         (lr_we),
        .lr_wdata      (lr_wdata),
        .pc            (pc),
        .retired       (retired),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
        if (lr_we === 1'b1) begin
            lw_cnt++;
            lw_data = lr_wdata;
        end
        if (decode_en === 1'b1) de_cnt++;
    endtask

    // Starts in a FETCH cycle; strobes {sdt,alu,br} are presented in the last DWAIT cycle.
    task automatic front(input logic [31:0] word, input logic [2:0] strb,
                         input logic cond, input logic link, input logic [23:0] off);
        ncyc = 0; lw_cnt = 0; de_cnt = 0; lw_data = 32'd0;
        imem_rdata = word;
        tick();
        chk("decode_en_after_fetch", {31'd0, decode_en}, 32'd1);
        tick();
        tick();
        tick();
        {sdt_en, alu_en, branch_en} = strb;
        branch_cond = cond; branch_link = link; branch_offset = off;
        tick();
        {sdt_en, alu_en, branch_en} = 3'b000;
        branch_cond = 1'b0; branch_link = 1'b0; branch_offset = 24'd0;
    endtask

    // done_sel {sdt,alu} pulses in EXEC cycle done_at; then run until the next FETCH (bounded).
    task automatic issue(input logic [31:0] word, input logic [2:0] strb, input logic cond,
                         input logic link, input logic [23:0] off,
                         input logic [1:0] done_sel, input int done_at);
        front(word, strb, cond, link, off);
        for (int k = 1; k <= done_at; k++) begin
            if (k == done_at) {sdt_done, alu_done} = done_sel;
            tick();
            {sdt_done, alu_done} = 2'b00;
        end
        while (imem_req !== 1'b1 && ncyc < 40) tick();
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'd0;
        branch_en = 0; branch_cond = 0; branch_link = 0; branch_offset = 24'd0;
        alu_en = 0; sdt_en = 0; alu_done = 0; sdt_done = 0;
        tick(); tick();
        chk("rst_pc", pc, 32'h100);
        chk("rst_retired", retired, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_lr_wdata", lr_wdata, 32'd0);
        chk("rst_ctrl", {28'd0, imem_req, decode_en, lr_we, fault}, 32'd0);
        rst = 1'b0;
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h100);

        // ALU, done in the 2nd EXEC cycle
        issue(32'hE081_0002, 3'b010, 0, 0, 24'd0, 2'b01, 2);
        chk("alu_cycles", ncyc, 32'd8);
        chk("alu_pc", pc, 32'h104);
        chk("alu_retired", retired, 32'd1);
        chk("alu_instr", instr, 32'hE081_0002);
        chk("alu_decode_cnt", de_cnt, 32'd1);
        chk("alu_no_lr", lw_cnt, 32'd0);

        // Taken branch 0x104 -> 0x200
        issue(32'hEA00_003D, 3'b001, 1, 0, 24'h00003D, 2'b00, 0);
        chk("b_cycles", ncyc, 32'd6);
        chk("b_pc", pc, 32'h200);
        chk("b_retired", retired, 32'd2);
        chk("b_no_lr", lw_cnt, 32'd0);

        // BL at 0x200, offset -2 words, lands on itself
        issue(32'hEBFF_FFFE, 3'b001, 1, 1, 24'hFFFFFE, 2'b00, 0);
        chk("bl_pc", pc, 32'h200);
        chk("bl_lr_cnt", lw_cnt, 32'd1);
        chk("bl_lr_data", lw_data, 32'h204);
        chk("bl_lr_hold", lr_wdata, 32'h204);
        chk("bl_retired", retired, 32'd3);

        // Branch not taken
        issue(32'h1B00_0010, 3'b001, 0, 1, 24'h000010, 2'b00, 0);
        chk("bnt_pc", pc, 32'h204);
        chk("bnt_no_lr", lw_cnt, 32'd0);
        chk("bnt_retired", retired, 32'd4);

        // SKIP: no strobe at all
        issue(32'h1081_0002, 3'b000, 0, 0, 24'd0, 2'b00, 0);
        chk("skip_cycles", ncyc, 32'd6);
        chk("skip_pc", pc, 32'h208);
        chk("skip_no_lr", lw_cnt, 32'd0);
        chk("skip_retired", retired, 32'd5);

        // SDT with done in the first EXEC cycle
        issue(32'hE591_0000, 3'b100, 0, 0, 24'd0, 2'b10, 1);
        chk("sdt_cycles", ncyc, 32'd7);
        chk("sdt_pc", pc, 32'h20C);
        chk("sdt_retired", retired, 32'd6);

        // SDT never completes; alu_done is the wrong unit and must be ignored
        front(32'hE591_0004, 3'b100, 0, 0, 24'd0);
        alu_done = 1'b1;
        chk("to_exec1_nofault", {31'd0, fault}, 32'd0);
        tick(); tick(); tick();
        alu_done = 1'b0;
        chk("to_exec4_nofault", {31'd0, fault}, 32'd0);
        tick();
        chk("to_fault", {31'd0, fault}, 32'd1);
        sdt_done = 1'b1;
        tick();
        sdt_done = 1'b0;
        tick(); tick();
        chk("to_pc_frozen", pc, 32'h20C);
        chk("to_retired_frozen", retired, 32'd6);
        chk("to_strobes_low", {30'd0, imem_req, decode_en}, 32'd0);
        chk("to_still_fault", {31'd0, fault}, 32'd1);

        rst = 1'b1;
        tick();
        chk("rst_after_fault_pc", pc, 32'h100);
        chk("rst_after_fault_fault", {31'd0, fault}, 32'd0);
        chk("rst_after_fault_retired", retired, 32'd0);
        rst = 1'b0;
        tick();

        // Two dispatch strobes in the same cycle
        front(32'hE000_0000, 3'b110, 0, 0, 24'd0);
        chk("dual_fault", {31'd0, fault}, 32'd1);
        chk("dual_pc", pc, 32'h100);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of EXEC
        front(32'hE081_0003, 3'b010, 0, 0, 24'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midexec_req_drop", {31'd0, imem_req}, 32'd0);
        chk("midexec_pc", pc, 32'h100);
        tick();
        chk("midexec_refetch_req", {31'd0, imem_req}, 32'd1);
        chk("midexec_refetch_addr", imem_addr, 32'h100);

        issue(32'hE081_0004, 3'b010, 0, 0, 24'd0, 2'b01, 1);
        chk("recover_cycles", ncyc, 32'd7);
        chk("recover_pc", pc, 32'h104);
        chk("recover_retired", retired, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        $display("FAIL watchdog expired observed=%0d cycles expected<5000", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arm7_sequencer.md
# arm7_sequencer

Top-level instruction sequencer for the ARM7 core. Owns the PC, fetches each instruction from instruction memory, holds it stable for the `decoder`, and pulses `decode_en`. It then samples the decoder's one-cycle `branch_en`/`alu_en`/`sdt_en` strobes, waits for the selected execution unit to finish, and commits the next PC and link register. It runs one instruction at a time with no overlap.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DECODE_LAT, 3, cycles after the `decode_en` cycle during which decoder strobes are sampled.
- EXEC_TIMEOUT, 255, maximum number of EXEC cycles before a fault (range 1..255).

Ports:
- clk  in  1  Single clock, rising edge. All state is clocked on this edge.
- rst  in  1  Synchronous, active-high reset.
- imem_req  out  1  Fetch request. Held high until `imem_ready` is sampled high.
- imem_addr  out  32  Fetch address; equals `pc`.
- imem_ready  in  1  Fetch complete; `imem_rdata` is valid in the same cycle.
- imem_rdata  in  32  Fetched instruction word.
- instr  out  32  Latched instruction word driven to the decoder.
- decode_en  out  1  One-cycle decode start pulse.
- branch_en, branch_cond, branch_link  in  1 each  Decoder branch strobe and its qualifiers.
- branch_offset  in  24  Signed word offset from the decoder.
- alu_en, sdt_en  in  1 each  Decoder dispatch strobes.
- alu_done, sdt_done  in  1 each  Execution-unit completion pulses.
- lr_we  out  1  One-cycle write strobe for R14.
- lr_wdata  out  32  Link value written to R14.
- pc  out  32  Current PC.
- retired  out  32  Count of committed instructions; wraps modulo 2^32.
- fault  out  1  Sticky error flag; cleared only by `rst`.

## Operation
- States and transitions:
  - RESET → FETCH.
  - FETCH → DECODE when `imem_ready` is sampled high.
  - DECODE → DWAIT.
  - DWAIT → EXEC, COMMIT or FAULT.
  - EXEC → COMMIT or FAULT.
  - COMMIT → FETCH.
  - FAULT is terminal.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On the `imem_ready` cycle, `instr` latches `imem_rdata`.
  - `instr` then holds its value until the next fetch completes.
- DECODE: `decode_en`=1 for exactly one cycle.
- DWAIT:
  - Lasts DECODE_LAT cycles. The first strobe seen is captured as the class: BR, ALU or SDT.
  - A branch also captures `branch_cond`, `branch_link` and `branch_offset`.
  - If more than one strobe is high in the same cycle, or a second strobe arrives after the first, go to FAULT.
  - If no strobe is seen, the class is SKIP (condition failed, non-branch) → COMMIT.
  - BR and SKIP go to COMMIT after the window closes. ALU and SDT go to EXEC.
- EXEC:
  - Waits for the done signal matching the class (`alu_done` or `sdt_done`). The other done signal is ignored.
  - If the count reaches EXEC_TIMEOUT with no done → FAULT.
- COMMIT:
  - Next PC:
    - BR with `branch_cond`=1: `pc` + 8 + (sign-extended offset << 2), truncated to 32 bits (wrap permitted).
    - Otherwise: `pc` + 4.
  - If BR, `branch_cond`=1 and `branch_link`=1: `lr_we`=1 and `lr_wdata`=old `pc` + 4.
  - `retired` increments for every class, SKIP included.
- FAULT: all strobes low, `fault`=1. `pc`, `retired` and `instr` are frozen.
- Done pulses and decoder strobes arriving outside the states that sample them are ignored.

## Timing
- Reset values:
  - `pc`=RESET_PC.
  - `instr`, `retired` and `lr_wdata` = 0.
  - `imem_req`, `decode_en`, `lr_we` and `fault` = 0.
  - State = RESET.
- `rst` overrides everything, including mid-fetch, mid-EXEC and FAULT. `imem_req` drops in the cycle after `rst` is sampled.
- Cycle numbering: D is the `decode_en` cycle. The decoder strobe is visible in cycle D+3, the last DWAIT cycle when DECODE_LAT=3.
- Minimum latency per instruction, with `imem_ready` seen in the first FETCH cycle:
  - BR and SKIP: 6 cycles (FETCH 1 + DECODE 1 + DWAIT 3 + COMMIT 1).
  - ALU and SDT: 7 cycles, with done sampled in the first EXEC cycle.
- EXEC starts the cycle after DWAIT ends. Done is sampled from the first EXEC cycle onward.
- `pc`, `retired` and `lr_wdata` update on the clock edge that ends COMMIT. `lr_we` is high only during COMMIT.

## Structure
- Shared package `arm7_pkg` contains:
  - the state enum;
  - the instruction-class enum (BR, ALU, SDT, SKIP);
  - constants PC_STEP=4 and PC_PIPE_OFFSET=8;
  - the condition-code defines, moved out of the decoder into the package.
- One sub-module, `arm7_branch_target`: combinational; takes `pc` and `branch_offset`, returns the 32-bit target.

## Test plan
- Reset: RESET_PC=0x100, `imem_ready` tied high.
  - Required: first `imem_addr`=0x100.
  - Required: `decode_en` pulses 1 cycle after fetch.
  - Required: `fault`=0.
- ALU instruction, `alu_done` 2 cycles into EXEC:
  - Required: `pc` 0x100→0x104.
  - Required: `retired`=1.
  - Required: 8 cycles total.
- BL at `pc`=0x200 with offset 24'hFFFFFE:
  - Required: `pc`=0x200.
  - Required: `lr_we` pulse with `lr_wdata`=0x204.
- Branch with `branch_cond`=0, and separately a SKIP with no strobes:
  - Required: `pc`+4 in both cases, no `lr_we`.
  - Required: `retired` increments in both cases.
- SDT with no `sdt_done` and EXEC_TIMEOUT=4:
  - Required: `fault`=1 after 4 EXEC cycles; `pc` frozen.
  - Required: pulsing `rst` restores RESET_PC and `fault`=0.
- `alu_en` and `sdt_en` both asserted in the same DWAIT cycle:
  - Required: FAULT.
  - Required: `rst` asserted mid-EXEC aborts and refetches from RESET_PC.
